// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file widths and the write-back entry type
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int REG_N  = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO holding pending load write-backs
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and load results onto the register-file write port
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int REG_AW = rv_pkg::REG_AW,
    parameter int DEPTH  = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_we,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic [REG_N-1:0]  busy,
    output logic [REG_AW-1:0] addr_w1,
    output logic [XLEN-1:0]   write,
    output logic              write_enable,
    output logic [CW-1:0]     fifo_count,
    output logic              waw_err
);

    logic [REG_AW-1:0] r_addr;
    logic [XLEN-1:0]   r_data;
    logic              r_we;
    logic [REG_N-1:0]  r_busy;
    logic              r_waw;

    logic              w_alu_req;
    logic              w_lsu_fire;
    logic              w_lsu_live;
    logic              w_sel_alu;
    logic              w_sel_fifo;
    logic              w_sel_byp;
    logic              w_sel_any;
    logic              w_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    wb_entry_t         w_lsu_entry;
    wb_entry_t         w_head;
    wb_entry_t         w_sel;
    logic [REG_N-1:0]  w_busy_nxt;

    assign w_lsu_entry = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .W     ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_lsu_entry),
        .i_pop   (w_sel_fifo),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Ready comes from registered FIFO occupancy only, so no comb path from valid
    assign lsu_ready  = !w_fifo_full;
    assign w_alu_req  = alu_we && (alu_rd != REG_ZERO);
    assign w_lsu_fire = lsu_valid && lsu_ready;
    assign w_lsu_live = w_lsu_fire && (lsu_rd != REG_ZERO);

    assign w_sel_alu  = w_alu_req;
    assign w_sel_fifo = !w_alu_req && !w_fifo_empty;
    assign w_sel_byp  = !w_alu_req && w_fifo_empty && w_lsu_live;
    assign w_sel_any  = w_sel_alu || w_sel_fifo || w_sel_byp;
    assign w_push     = w_lsu_live && !w_sel_byp;

    always_comb begin
        w_sel = w_lsu_entry;
        if (w_sel_alu) begin
            w_sel = '{rd: alu_rd, data: alu_data};
        end else if (w_sel_fifo) begin
            w_sel = w_head;
        end
    end

    // Clear on load completion first so a same-cycle issue to that register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_sel_fifo || w_sel_byp) begin
            w_busy_nxt[w_sel.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != REG_ZERO)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_we   <= 1'b0;
            r_busy <= '0;
            r_waw  <= 1'b0;
        end else begin
            r_we   <= w_sel_any;
            r_busy <= w_busy_nxt;
            if (w_sel_any) begin
                r_addr <= w_sel.rd;
                r_data <= w_sel.data;
            end
            if (w_sel_alu && r_busy[alu_rd]) begin
                r_waw <= 1'b1;
            end
        end
    end

    assign addr_w1      = r_addr;
    assign write        = r_data;
    assign write_enable = r_we;
    assign busy         = r_busy;
    assign fifo_count   = w_fifo_count;
    assign waw_err      = r_waw;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_we = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] busy;
    logic [4:0]  addr_w1;
    logic [31:0] write;
    logic        write_enable;
    logic [1:0]  fifo_count;
    logic        waw_err;

    int n_chk = 0;
    int n_pass = 0;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_we       (alu_we),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .busy         (busy),
        .addr_w1      (addr_w1),
        .write        (write),
        .write_enable (write_enable),
        .fifo_count   (fifo_count),
        .waw_err      (waw_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_we;
        logic [4:0]  a_rd;
        logic [31:0] a_data;
        logic        l_v;
        logic [4:0]  l_rd;
        logic [31:0] l_data;
        logic        i_v;
        logic [4:0]  i_rd;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        logic [1:0]  e_cnt;
        logic        e_waw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    endtask

    task automatic drive(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ir);
        alu_we = aw; alu_rd = ar; alu_data = ad;
        lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
        issue_valid = iv; issue_rd = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  bp_cnt   [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic        bp_ready [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0]  bp_addr  [8] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd20, 5'd21, 5'd22};
    logic [31:0] bp_data  [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1004,
                                  32'h200, 32'h201, 32'h202};

    initial begin
        // alu: we rd data | lsu: v rd data | issue: v rd | expect: we addr data busy cnt waw
        vecs.push_back('{1, 9, 32'h20, 0, 0, 0,     0, 0, 1, 9, 32'h20, 32'h0,      0, 0});
        vecs.push_back('{0, 0, 0,      0, 0, 0,     0, 0, 0, 9, 32'h20, 32'h0,      0, 0});
        vecs.push_back('{0, 0, 0,      0, 0, 0,     1, 6, 0, 9, 32'h20, 32'h40,     0, 0});
        vecs.push_back('{0, 0, 0,      1, 6, 32'h40, 0, 0, 1, 6, 32'h40, 32'h0,     0, 0});
        vecs.push_back('{1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 1, 3, 32'h11, 32'h0,     1, 0});
        vecs.push_back('{0, 0, 0,      0, 0, 0,     0, 0, 1, 4, 32'h22, 32'h0,      0, 0});
        vecs.push_back('{0, 0, 0,      0, 0, 0,     0, 0, 0, 4, 32'h22, 32'h0,      0, 0});
        vecs.push_back('{1, 0, 32'h55, 0, 0, 0,     0, 0, 0, 4, 32'h22, 32'h0,      0, 0});
        vecs.push_back('{0, 0, 0,      1, 0, 32'h66, 0, 0, 0, 4, 32'h22, 32'h0,     0, 0});
        vecs.push_back('{1, 0, 32'h99, 1, 7, 32'h77, 0, 0, 1, 7, 32'h77, 32'h0,     0, 0});
        vecs.push_back('{0, 0, 0,      0, 0, 0,     1, 5, 0, 7, 32'h77, 32'h20,     0, 0});
        vecs.push_back('{1, 5, 32'hAA, 0, 0, 0,     0, 0, 1, 5, 32'hAA, 32'h20,     0, 1});
        vecs.push_back('{0, 0, 0,      0, 0, 0,     0, 0, 0, 5, 32'hAA, 32'h20,     0, 1});
        vecs.push_back('{0, 0, 0,      1, 5, 32'hBB, 1, 5, 1, 5, 32'hBB, 32'h20,    0, 1});
        vecs.push_back('{0, 0, 0,      1, 5, 32'hCC, 0, 0, 1, 5, 32'hCC, 32'h0,     0, 1});

        #12;
        chk("reset_we", {31'b0, write_enable}, 32'd0);
        chk("reset_addr", {27'b0, addr_w1}, 32'd0);
        chk("reset_write", write, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_cnt", {30'b0, fifo_count}, 32'd0);
        chk("reset_waw", {31'b0, waw_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", {31'b0, lsu_ready}, 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].a_we, vecs[i].a_rd, vecs[i].a_data, vecs[i].l_v, vecs[i].l_rd,
                  vecs[i].l_data, vecs[i].i_v, vecs[i].i_rd);
            tick();
            chk($sformatf("v%0d_we", i), {31'b0, write_enable}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_addr", i), {27'b0, addr_w1}, {27'b0, vecs[i].e_addr});
            chk($sformatf("v%0d_write", i), write, vecs[i].e_data);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_cnt", i), {30'b0, fifo_count}, {30'b0, vecs[i].e_cnt});
            chk($sformatf("v%0d_waw", i), {31'b0, waw_err}, {31'b0, vecs[i].e_waw});
            chk($sformatf("v%0d_ready", i), {31'b0, lsu_ready}, 32'd1);
        end

        // Backpressure: five ALU writes while three loads are offered
        begin
            int k = 0;
            for (int c = 0; c < 8; c++) begin
                logic fire;
                drive(c < 5, 5'(10 + c), 32'h1000 + c, k < 3, 5'(20 + k), 32'h200 + k, 0, 0);
                chk($sformatf("bp%0d_ready", c), {31'b0, lsu_ready}, {31'b0, bp_ready[c]});
                fire = lsu_valid && lsu_ready;
                tick();
                if (fire) k++;
                chk($sformatf("bp%0d_we", c), {31'b0, write_enable}, 32'd1);
                chk($sformatf("bp%0d_addr", c), {27'b0, addr_w1}, {27'b0, bp_addr[c]});
                chk($sformatf("bp%0d_write", c), write, bp_data[c]);
                chk($sformatf("bp%0d_cnt", c), {30'b0, fifo_count}, {30'b0, bp_cnt[c]});
            end
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            chk("bp_done_we", {31'b0, write_enable}, 32'd0);
            chk("bp_transfers", k, 32'd3);
        end

        // Fill FIFO to two entries, then reset asynchronously mid-cycle
        drive(1, 1, 32'h1, 1, 2, 32'h2, 1, 8);
        tick();
        drive(1, 1, 32'h3, 1, 3, 32'h4, 0, 0);
        tick();
        chk("pre_rst_cnt", {30'b0, fifo_count}, 32'd2);
        chk("pre_rst_busy", busy, 32'h100);
        chk("pre_rst_waw", {31'b0, waw_err}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'b0, write_enable}, 32'd0);
        chk("arst_addr", {27'b0, addr_w1}, 32'd0);
        chk("arst_write", write, 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_cnt", {30'b0, fifo_count}, 32'd0);
        chk("arst_waw", {31'b0, waw_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, lsu_ready}, 32'd1);
        tick();
        chk("post_rst_we", {31'b0, write_enable}, 32'd0);
        chk("post_rst_cnt", {30'b0, fifo_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back arbiter that sits directly upstream of the 32x32 register file and drives its single write port (addr_w1 / write / write_enable).
- Merges two result sources:
  - the single-cycle ALU path, which is always accepted;
  - a long-latency load/store result path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a 32-bit busy scoreboard of registers awaiting a long-latency result, so decode can stall on RAW/WAW hazards.

Parameters:
XLEN, 32, data width of register values
REG_AW, 5, register address width (32 architectural registers)
DEPTH, 2, load-result FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_we  in  1  ALU result valid this cycle
alu_rd  in  REG_AW  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load result offered
lsu_ready  out  1  arbiter can accept load result
lsu_rd  in  REG_AW  load destination register
lsu_data  in  XLEN  load result data
issue_valid  in  1  a long-latency op was issued this cycle
issue_rd  in  REG_AW  destination of issued op
busy  out  32  scoreboard; bit n = register n awaits a load result
addr_w1  out  REG_AW  register-file write address
write  out  XLEN  register-file write data
write_enable  out  1  register-file write strobe
fifo_count  out  $clog2(DEPTH)+1  entries currently buffered
waw_err  out  1  sticky flag: ALU wrote a register marked busy

Behaviour:
- Reset (rst_n low, asynchronous; takes effect immediately, including mid-operation):
  - addr_w1 = 0, write = 0, write_enable = 0, busy = 0, fifo_count = 0, waw_err = 0.
  - FIFO pointers cleared and buffered entries discarded.
  - lsu_ready = 1 once reset deasserts.
- Outputs addr_w1, write and write_enable are registered.
  - A result selected in cycle N appears on the port in cycle N+1.
  - The register file commits it at the edge ending cycle N+1.
- Handshake: a load transfer occurs on a rising edge where lsu_valid && lsu_ready.
  - lsu_ready = (fifo_count < DEPTH). It depends only on registered state, never on lsu_valid or alu_we.
- x0 filtering:
  - alu_we with alu_rd = 0 is treated as no request.
  - A load transfer with lsu_rd = 0 completes the handshake but is dropped: not enqueued, never written.
- Arbitration each cycle, first match wins:
  - 1. alu_we && alu_rd != 0: ALU result selected.
  - 2. FIFO not empty: FIFO head popped and selected.
  - 3. FIFO empty, load transfer this cycle, lsu_rd != 0: incoming load bypasses the FIFO and is selected.
  - 4. Otherwise write_enable = 0 next cycle; addr_w1 and write hold their previous values.
- Enqueue rules:
  - A transferred load is enqueued unless it was bypassed (case 3) or dropped (x0).
  - Push and pop may occur in the same cycle; fifo_count is then unchanged.
  - Ordering: load results commit in exact transfer order. An ALU result may overtake buffered load results.
- Starvation: continuous ALU writes stall the FIFO. lsu_ready falls once the FIFO is full. No overflow is possible.
- Scoreboard:
  - busy[issue_rd] is set at the edge where issue_valid && issue_rd != 0.
  - busy[r] is cleared at the edge where a load result for r is selected (cases 2 or 3).
  - Same r set and cleared in the same cycle: set wins.
  - busy[0] is hard 0.
- waw_err: set at the edge where an ALU result is selected with busy[alu_rd] = 1. The write still proceeds. Cleared only by reset.

Decomposition:
- Shared package (rv_pkg): XLEN, REG_AW, REG_N = 32, REG_ZERO = 5'd0, and a wb_entry struct holding rd and data.
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO.
  - Carries {rd, data} with push, pop, full, empty and count outputs.
  - Uses the same asynchronous active-low reset.
- Arbitration, bypass, scoreboard and output registers live in wb_arbiter.

Test Plan:
- Reset then ALU only: alu_we=1, alu_rd=9, alu_data=0x20 in cycle N. Next cycle: addr_w1=9, write=0x20, write_enable=1. Cycle after: write_enable=0.
- Load bypass: issue_valid=1, issue_rd=6, so busy[6]=1. Then lsu_valid=1, lsu_rd=6, lsu_data=0x40 with FIFO empty and no ALU. Next cycle: write_enable=1, addr_w1=6, write=0x40; busy[6] returns to 0 and fifo_count stays 0.
- Collision: ALU (rd=3, 0x11) and load (rd=4, 0x22) in the same cycle. Required:
  - ALU written first, load enqueued (fifo_count=1).
  - Load written one cycle later.
  - fifo_count back to 0.
- Backpressure: hold alu_we=1 for 5 cycles while offering 3 loads.
  - lsu_ready drops after 2 accepted transfers.
  - Loads then drain in order after the ALU burst.
  - No entry is lost or duplicated.
- x0 handling: alu_rd=0 with alu_we=1 -> write_enable stays 0. A load with lsu_rd=0 -> handshake completes, fifo_count stays 0, no write.
- Hazard and reset: set busy[5] via issue, then ALU writes rd=5 -> waw_err=1 and stays sticky. Assert rst_n low mid-drain with fifo_count=2 -> all outputs, busy and fifo_count are 0 immediately.
